id_ex_pipe: RTL and testbench
=============================

// Module: id_ex_pipe
// PURPOSE
//   ID->EX pipeline boundary. Captures the decoded instruction bundle (pc, op, funct, operand_1,
//   operand_2, store data, writeback control) produced by the ID-stage operand generator and hands
//   it to EX with a valid/ready handshake. A 2-entry buffer (main + skid) lets ID see a registered
//   ready, so EX back-pressure never forms a combinational path into ID. Flush support for branch
//   and exception squash.
// PARAMETERS
//   DATA_W      32  operand / store-data width
//   ADDR_W      32  instruction address width
//   REG_ADDR_W  5   GPR index width
//   CNT_W       16  width of stall-cycle counter
// PORTS
//   clk                 in   1           clock, rising edge
//   rst                 in   1           asynchronous, active-low reset
//   flush               in   1           synchronous squash of all buffered entries
//   id_valid            in   1           ID bundle valid
//   id_ready            out  1           pipe can accept a bundle (registered)
//   id_addr             in   ADDR_W      instruction pc
//   id_op               in   6           opcode
//   id_funct            in   6           funct field
//   id_operand_1        in   DATA_W      ALU operand 1
//   id_operand_2        in   DATA_W      ALU operand 2
//   id_mem_data         in   DATA_W      store data (rt value)
//   id_reg_write_en     in   1           GPR writeback enable
//   id_reg_write_addr   in   REG_ADDR_W  GPR writeback index
//   ex_valid            out  1           EX bundle valid
//   ex_ready            in   1           EX accepts bundle this cycle
//   ex_addr, ex_op, ex_funct, ex_operand_1, ex_operand_2, ex_mem_data, ex_reg_write_en,
//   ex_reg_write_addr   out  (as id_*)   bundle presented to EX
//   stall_cycles        out  CNT_W       saturating count of cycles with ex_valid && !ex_ready
// BEHAVIOUR
//   - Reset (rst=0, async): main/skid valid=0, all payload regs=0, id_ready=1, stall_cycles=0.
//   - Accept: id_valid && id_ready at a clk edge. Issue: ex_valid && ex_ready at a clk edge.
//   - Latency: bundle accepted at edge N appears on ex_* with ex_valid=1 after edge N (1 cycle).
//   - States: EMPTY (no entries), ONE (main valid), FULL (main+skid valid).
//     EMPTY: accept -> ONE (load main).
//     ONE: accept&issue -> ONE (main<=input); accept&!issue -> FULL (skid<=input);
//          !accept&issue -> EMPTY; else hold.
//     FULL: issue -> ONE (main<=skid); no accept possible (id_ready=0).
//   - id_ready is a flop: 1 in EMPTY/ONE, 0 in FULL; updated with the state.
//   - ex_* driven from main entry. When ex_valid=0 all ex_* payload outputs read 0 (NOP bubble:
//     op=0, funct=0, reg_write_en=0).
//   - Payload held stable while ex_valid && !ex_ready. Strict FIFO order, no drop, no duplicate.
//   - flush=1: next state EMPTY, id_ready=1, any bundle accepted or issued that cycle is discarded
//     from the pipe (issue to EX still counts as issued). flush dominates accept/issue.
//   - stall_cycles increments on each edge with ex_valid && !ex_ready; saturates at 2^CNT_W-1;
//     not cleared by flush, only by reset.
//   - Async reset asserted mid-transfer: all state cleared immediately; ex_valid falls without
//     waiting for clk.
// TESTING
//   1. Stream: id_valid=1, ex_ready=1, addr 0x0,0x4,0x8 -> ex_addr same order, 1-cycle latency,
//      id_ready stays 1.
//   2. Back-pressure: ex_ready=0 with 3 offered bundles -> 2 accepted, id_ready=0 next cycle,
//      ex_addr held at first; release -> order preserved, stall_cycles = held cycles.
//   3. Flush in FULL: flush=1 -> next cycle ex_valid=0, ex_op=0, ex_reg_write_en=0, id_ready=1.
//   4. Flush with simultaneous accept of addr 0x20 -> 0x20 never appears on ex_addr.
//   5. Saturation (CNT_W=4): 20 stall cycles -> stall_cycles=15.
//   6. Async reset asserted between edges while FULL -> ex_valid=0, id_ready=1, all ex_* = 0
//      before next edge.

Source files
------------

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline boundary.
//
// Holds the decoded instruction bundle from the ID-stage operand generator and presents it to EX
// under a valid/ready handshake. The two-entry buffer (main + skid) means id_ready comes straight
// from a flop, so EX back-pressure never forms a combinational path into ID.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   flush                    synchronous squash of every buffered bundle
//   id_valid / id_ready      ID-side handshake (id_ready is registered)
//   id_*                     incoming bundle: pc, op, funct, operands, store data, writeback ctrl
//   ex_valid / ex_ready      EX-side handshake
//   ex_*                     bundle presented to EX, forced to an all-zero NOP while ex_valid=0
//   stall_cycles             saturating count of edges with ex_valid && !ex_ready
module id_ex_pipe #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [ADDR_W-1:0]     id_addr,
  input  logic [5:0]            id_op,
  input  logic [5:0]            id_funct,
  input  logic [DATA_W-1:0]     id_operand_1,
  input  logic [DATA_W-1:0]     id_operand_2,
  input  logic [DATA_W-1:0]     id_mem_data,
  input  logic                  id_reg_write_en,
  input  logic [REG_ADDR_W-1:0] id_reg_write_addr,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [ADDR_W-1:0]     ex_addr,
  output logic [5:0]            ex_op,
  output logic [5:0]            ex_funct,
  output logic [DATA_W-1:0]     ex_operand_1,
  output logic [DATA_W-1:0]     ex_operand_2,
  output logic [DATA_W-1:0]     ex_mem_data,
  output logic                  ex_reg_write_en,
  output logic [REG_ADDR_W-1:0] ex_reg_write_addr,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int unsigned PL_W = ADDR_W + 6 + 6 + 3 * DATA_W + 1 + REG_ADDR_W;

  // Occupancy of the two-entry buffer.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [PL_W-1:0]  main_q, main_d;
  logic [PL_W-1:0]  skid_q, skid_d;
  logic             id_ready_q, id_ready_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic             main_valid;
  logic             accept;
  logic             issue;
  logic [PL_W-1:0]  id_bundle;
  logic [PL_W-1:0]  ex_bundle;

  assign id_bundle = {id_addr, id_op, id_funct, id_operand_1, id_operand_2, id_mem_data,
                      id_reg_write_en, id_reg_write_addr};

  // ex_valid is decoded from the state flop, so an async reset drops it without a clock edge.
  assign main_valid = (state_q != ST_EMPTY);
  assign accept     = id_valid && id_ready_q;
  assign issue      = main_valid && ex_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = id_bundle;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && issue) begin
          main_d = id_bundle;
        end else if (accept) begin
          skid_d  = id_bundle;
          state_d = ST_FULL;
        end else if (issue) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // id_ready is low here, so only the skid-to-main shift can happen.
        if (issue) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Squash wins over everything; payload regs may still load but are invisible while empty.
    if (flush) begin
      state_d = ST_EMPTY;
    end

    id_ready_d = (state_d != ST_FULL);
  end

  always_comb begin
    stall_d = stall_q;
    if (main_valid && !ex_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      id_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      id_ready_q <= id_ready_d;
      stall_q    <= stall_d;
    end
  end

  // Bubble: everything reads zero (op=0, funct=0, reg_write_en=0) when nothing is valid.
  assign ex_bundle = main_valid ? main_q : '0;

  assign {ex_addr, ex_op, ex_funct, ex_operand_1, ex_operand_2, ex_mem_data,
          ex_reg_write_en, ex_reg_write_addr} = ex_bundle;

  assign ex_valid     = main_valid;
  assign id_ready     = id_ready_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] md;
    logic        we;
    logic [4:0]  wa;
  } bundle_t;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             id_valid;
  logic             id_ready;
  logic             ex_valid;
  logic             ex_ready;
  logic [CNT_W-1:0] stall_cycles;
  bundle_t          drv;
  bundle_t          got;

  logic [31:0] ex_addr;
  logic [5:0]  ex_op;
  logic [5:0]  ex_funct;
  logic [31:0] ex_operand_1;
  logic [31:0] ex_operand_2;
  logic [31:0] ex_mem_data;
  logic        ex_reg_write_en;
  logic [4:0]  ex_reg_write_addr;

  id_ex_pipe #(
    .DATA_W     (32),
    .ADDR_W     (32),
    .REG_ADDR_W (5),
    .CNT_W      (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .id_valid          (id_valid),
    .id_ready          (id_ready),
    .id_addr           (drv.addr),
    .id_op             (drv.op),
    .id_funct          (drv.funct),
    .id_operand_1      (drv.op1),
    .id_operand_2      (drv.op2),
    .id_mem_data       (drv.md),
    .id_reg_write_en   (drv.we),
    .id_reg_write_addr (drv.wa),
    .ex_valid          (ex_valid),
    .ex_ready          (ex_ready),
    .ex_addr           (ex_addr),
    .ex_op             (ex_op),
    .ex_funct          (ex_funct),
    .ex_operand_1      (ex_operand_1),
    .ex_operand_2      (ex_operand_2),
    .ex_mem_data       (ex_mem_data),
    .ex_reg_write_en   (ex_reg_write_en),
    .ex_reg_write_addr (ex_reg_write_addr),
    .stall_cycles      (stall_cycles)
  );

  assign got = {ex_addr, ex_op, ex_funct, ex_operand_1, ex_operand_2, ex_mem_data,
                ex_reg_write_en, ex_reg_write_addr};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the pipe is a FIFO of at most two bundles.
  bundle_t exp_q[$];
  logic    exp_ready;
  int      stall_m;
  int      checks;
  int      errors;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, pop and compare whenever the DUT hands a bundle to EX.
  initial begin
    bundle_t e;
    forever begin
      @(negedge clk);
      if (ex_valid === 1'b1) begin
        if (ex_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_unexpected: got addr %h expected no issue", ex_addr);
          end else begin
            e = exp_q.pop_front();
            chk("issue_bundle", got, e);
          end
        end
      end else begin
        chk("bubble_zero", got, '0);
      end
    end
  end

  // One cycle of stimulus, starting and ending at posedge+1.
  task automatic step(input logic v, input logic r, input logic f, input logic [31:0] a);
    bundle_t b;
    b.addr  = a;
    b.op    = 6'($urandom);
    b.funct = 6'($urandom);
    b.op1   = $urandom;
    b.op2   = $urandom;
    b.md    = $urandom;
    b.we    = 1'($urandom);
    b.wa    = 5'($urandom);
    drv      = b;
    id_valid = v;
    ex_ready = r;
    flush    = f;
    @(posedge clk);
    // An issue this edge was already popped by the monitor, so a non-empty model means held.
    if (!r && exp_q.size() > 0 && stall_m != CNT_MAX) stall_m++;
    if (f) exp_q.delete();
    else if (v && exp_ready) exp_q.push_back(b);
    exp_ready = (exp_q.size() < 2);
    #1;
    chk("id_ready", id_ready, exp_ready);
    chk("ex_valid", ex_valid, exp_q.size() > 0);
    chk("stall_cycles", stall_cycles, stall_m);
    if (exp_q.size() > 0) chk("ex_addr_head", ex_addr, exp_q[0].addr);
  endtask

  // Called at posedge+1; reset lands before the next negedge.
  task automatic async_reset();
    #3;
    rst      = 1'b0;
    id_valid = 1'b0;
    flush    = 1'b0;
    exp_q.delete();
    stall_m   = 0;
    exp_ready = 1'b1;
    #1;
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_id_ready", id_ready, 1'b1);
    chk("rst_ex_payload", got, '0);
    chk("rst_stall", stall_cycles, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    stall_m   = 0;
    exp_ready = 1'b1;
    rst       = 1'b0;
    flush     = 1'b0;
    id_valid  = 1'b0;
    ex_ready  = 1'b0;
    drv       = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ex_valid", ex_valid, 1'b0);
    chk("reset_id_ready", id_ready, 1'b1);
    chk("reset_payload", got, '0);
    chk("reset_stall", stall_cycles, '0);
    rst = 1'b1;

    // Stream at full rate.
    step(1, 1, 0, 32'h0);
    step(1, 1, 0, 32'h4);
    step(1, 1, 0, 32'h8);
    step(0, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);

    // Back-pressure: third offer is refused, then release.
    step(1, 0, 0, 32'h100);
    step(1, 0, 0, 32'h104);
    step(1, 0, 0, 32'h108);
    step(0, 0, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);

    // Flush while full.
    step(1, 0, 0, 32'h200);
    step(1, 0, 0, 32'h204);
    step(0, 0, 1, 32'h0);
    chk("flush_full_op", ex_op, 6'd0);
    chk("flush_full_we", ex_reg_write_en, 1'b0);
    step(0, 1, 0, 32'h0);

    // Flush coinciding with acceptance of 0x20.
    step(1, 1, 0, 32'h1c);
    step(1, 1, 1, 32'h20);
    step(0, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);

    // Saturation of the stall counter.
    step(1, 0, 0, 32'h300);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 32'h0);
    chk("stall_saturated", stall_cycles, CNT_MAX);

    // Async reset while full.
    step(1, 1, 0, 32'h400);
    step(1, 0, 0, 32'h404);
    async_reset();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
           {$urandom_range(0, 1023), 2'b00});
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
